// File: rtl/cv32e40p_pkg.sv
// Shared types for the EX-stage divider: operator and sequencer state encodings.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    DIVU = 2'b00,
    DIV  = 2'b01,
    REMU = 2'b10,
    REM  = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_FINISH
  } div_state_e;

  localparam int DIV_CNT_W = $clog2(32) + 1;

endpackage

// File: rtl/cv32e40p_div_clz.sv
// Combinational 32-bit leading-zero counter; all-zero input yields 32.
module cv32e40p_div_clz (
  input  logic [31:0] data_i,
  output logic [5:0]  clz_o
);

  // Ascending scan: the highest set bit is the last writer.
  always_comb begin
    clz_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) clz_o = 6'(31 - i);
    end
  end

endmodule

// File: rtl/cv32e40p_div_seq.sv
// Iterative radix-2 restoring divider sequencer (DIV/DIVU/REM/REMU) for EX.
// Define CV32E40P_DIV_EARLY_OUT_EN to skip the dividend's leading zeros.
module cv32e40p_div_seq
  import cv32e40p_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [1:0]       operator_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  input  logic             ex_ready_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  div_state_e           state_q;
  div_op_e              op_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [31:0]          rem_q;
  logic [31:0]          dvd_q;
  logic [31:0]          dvs_q;
  logic                 neg_q_q, neg_r_q;
  logic                 valid_q;
  logic [31:0]          result_q;

  // Operand conditioning at accept
  logic                 signed_op;
  logic [31:0]          mag_a, mag_b;
  logic                 neg_q_in, neg_r_in;
  logic [31:0]          dvd_init;
  logic [DIV_CNT_W-1:0] cnt_init;

  assign signed_op = operator_i[0];
  assign mag_a     = (signed_op & op_a_i[31]) ? -op_a_i : op_a_i;
  assign mag_b     = (signed_op & op_b_i[31]) ? -op_b_i : op_b_i;
  assign neg_q_in  = signed_op & (op_a_i[31] ^ op_b_i[31]) & (op_b_i != '0);
  assign neg_r_in  = signed_op & op_a_i[31];

`ifdef CV32E40P_DIV_EARLY_OUT_EN
  logic [5:0] clz;

  cv32e40p_div_clz u_clz (
    .data_i (mag_a),
    .clz_o  (clz)
  );

  // A zero dividend still takes one iteration so the FSM path is uniform.
  assign dvd_init = mag_a << clz;
  assign cnt_init = clz[5] ? '0 : {1'b0, 5'd31 - clz[4:0]};
`else
  assign dvd_init = mag_a;
  assign cnt_init = DIV_CNT_W'(WIDTH - 1);
`endif

  // One restoring step; the 33rd bit only exists in the shifted trial value.
  logic [32:0] rem_shift, trial;
  logic        qbit;
  logic [31:0] rem_nxt, quo_nxt, res_fin;

  assign rem_shift = {rem_q, dvd_q[31]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign qbit      = rem_shift >= {1'b0, dvs_q};
  assign rem_nxt   = qbit ? trial[31:0] : rem_shift[31:0];
  assign quo_nxt   = {dvd_q[30:0], qbit};

  always_comb begin
    res_fin = neg_q_q ? -quo_nxt : quo_nxt;
    if ((op_q == REMU) || (op_q == REM)) res_fin = neg_r_q ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= DIVU;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (kill_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            op_q    <= div_op_e'(operator_i);
            dvd_q   <= dvd_init;
            dvs_q   <= mag_b;
            neg_q_q <= neg_q_in;
            neg_r_q <= neg_r_in;
            rem_q   <= '0;
            cnt_q   <= cnt_init;
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          rem_q <= rem_nxt;
          dvd_q <= quo_nxt;
          if (cnt_q == '0) begin
            state_q  <= ST_FINISH;
            valid_q  <= 1'b1;
            result_q <= res_fin;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FINISH: begin
          // A request arriving with ex_ready_i waits for the next IDLE cycle.
          if (ex_ready_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == ST_IDLE) ? ~enable_i : (state_q == ST_FINISH);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_cv32e40p_div_seq.sv
// Self-checking bench for cv32e40p_div_seq: vector table, random ops vs model, corner sequences.
module tb_cv32e40p_div_seq;

  localparam logic [1:0] OP_DIVU = 2'b00, OP_DIV = 2'b01, OP_REMU = 2'b10, OP_REM = 2'b11;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable_i = 1'b0, kill_i = 1'b0, ex_ready_i = 1'b0;
  logic [1:0]  operator_i = '0;
  logic [31:0] op_a_i = '0, op_b_i = '0;
  logic        ready_o, valid_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  cv32e40p_div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .operator_i (operator_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .kill_i     (kill_i),
    .ex_ready_i (ex_ready_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
      if (op[1]) return sa % sb;
      return sa / sb;
    end
    if (op[1]) return a % b;
    return a / b;
  endfunction

  // Cycle (counted from accept) in which valid_o should first be high.
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a);
`ifdef CV32E40P_DIV_EARLY_OUT_EN
    logic [31:0] m;
    m = (op[0] && a[31]) ? -a : a;
    if (m == 32'h0) return 2;
    return $clog2({32'h0, m} + 64'd1) + 1;
`else
    return (op == 2'b00 || a != 32'h1) ? 33 : 33;
`endif
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    enable_i   = 1'b1;
  endtask

  // Called in the accept cycle; returns result and the cycle valid_o rose.
  task automatic wait_done(input string name, output logic [31:0] res, output int lat);
    logic rdy_bad;
    rdy_bad = 1'b0;
    lat = 0;
    #1;
    if (ready_o !== 1'b0) rdy_bad = 1'b1;
    while (lat < 200) begin
      @(posedge clk); #2;
      lat++;
      if (valid_o === 1'b1) break;
      if (ready_o !== 1'b0) rdy_bad = 1'b1;
    end
    res = result_o;
    chk({name, " ready_low_busy"}, {31'h0, rdy_bad}, 32'h0);
  endtask

  task automatic retire(input string name);
    ex_ready_i = 1'b1;
    @(posedge clk); #1;
    enable_i   = 1'b0;
    ex_ready_i = 1'b0;
    #1;
    chk({name, " idle_ready"}, {31'h0, ready_o}, 32'h1);
    chk({name, " idle_valid"}, {31'h0, valid_o}, 32'h0);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] r;
    int          lat;
    start_op(op, a, b);
    wait_done(name, r, lat);
    chk({name, " result"}, r, exp);
    chk({name, " latency"}, lat, exp_lat(op, a));
    retire(name);
  endtask

  initial begin
    logic [31:0] r, a, b;
    int          lat;
    logic [1:0]  op;
    logic        seen;

    tbl[0]  = '{OP_DIVU, 32'd100,        32'd7,        32'd14};
    tbl[1]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF};
    tbl[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD};
    tbl[3]  = '{OP_DIV,  32'h1234_5678,  32'd0,        32'hFFFF_FFFF};
    tbl[4]  = '{OP_REM,  32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFB};
    tbl[5]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    tbl[6]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
    tbl[7]  = '{OP_REMU, 32'd100,        32'd7,        32'd2};
    tbl[8]  = '{OP_DIVU, 32'd5,          32'd1,        32'd5};
    tbl[9]  = '{OP_DIVU, 32'd0,          32'd9,        32'd0};
    tbl[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd0,        32'hFFFF_FFFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {31'h0, ready_o}, 32'h1);
    chk("reset valid", {31'h0, valid_o}, 32'h0);
    chk("reset result", result_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Random operations against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = 32'($urandom_range(0, 2));
      endcase
      run($sformatf("rand%0d", i), op, a, b, ref_res(op, a, b));
    end

    // Flush in the middle of an iteration
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    kill_i   = 1'b1;
    enable_i = 1'b0;
    @(posedge clk); #1;
    kill_i = 1'b0;
    #1;
    chk("kill valid", {31'h0, valid_o}, 32'h0);
    chk("kill ready", {31'h0, ready_o}, 32'h1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #2;
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    chk("kill no_valid", {31'h0, seen}, 32'h0);
    run("after_kill", OP_DIVU, 32'd9, 32'd3, 32'd3);

    // Flush beats a simultaneous request
    start_op(OP_DIVU, 32'd9, 32'd3);
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i   = 1'b0;
    enable_i = 1'b0;
    #1;
    chk("kill_vs_enable ready", {31'h0, ready_o}, 32'h1);

    // Result held while EX stalls, then back-to-back request
    start_op(OP_DIVU, 32'd77, 32'd5);
    wait_done("hold", r, lat);
    chk("hold result", r, 32'd15);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk($sformatf("hold%0d valid", i), {31'h0, valid_o}, 32'h1);
      chk($sformatf("hold%0d result", i), result_o, 32'd15);
    end
    start_op(OP_DIVU, 32'd50, 32'd5);
    ex_ready_i = 1'b1;
    @(posedge clk); #1;
    ex_ready_i = 1'b0;
    #1;
    chk("b2b idle valid", {31'h0, valid_o}, 32'h0);
    chk("b2b idle ready", {31'h0, ready_o}, 32'h0);
    wait_done("b2b", r, lat);
    chk("b2b result", r, 32'd10);
    chk("b2b latency", lat, exp_lat(OP_DIVU, 32'd50));
    retire("b2b");

    // Asynchronous reset mid-operation
    start_op(OP_DIVU, 32'd1000, 32'd7);
    repeat (5) @(posedge clk);
    #3;
    enable_i = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("areset ready", {31'h0, ready_o}, 32'h1);
    chk("areset valid", {31'h0, valid_o}, 32'h0);
    chk("areset result", result_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("after_reset", OP_REMU, 32'd1000, 32'd7, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
